// File: rtl/alu_seq_div_if.sv
// Request/result bundle for the sequential unsigned divider.
// The master drives the operands and start strobe; the slave returns the result.
interface alu_seq_div_if #(parameter int BITS = 8);
  logic            i_start;
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic            o_busy;
  logic            o_done;
  logic [BITS-1:0] o_quot;
  logic [BITS-1:0] o_rem;
  logic            o_div_zero;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_quot, o_rem, o_div_zero
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_quot, o_rem, o_div_zero
  );
endinterface

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// IDLE -> CALC (BITS steps) -> DONE (one cycle) -> IDLE; divide by zero
// short-circuits IDLE -> DONE with quot = all ones and rem = dividend.
module alu_seq_div #(
  parameter int BITS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_seq_div_if.slave bus
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] dvd;   // dividend; quotient bits shift in from the LSB
  logic [BITS-1:0] dvs;   // latched divisor
  logic [BITS-1:0] prem;  // partial remainder, always < dvs between steps

  logic [BITS:0]   shifted;
  logic            borrow;
  logic            qbit;
  logic [BITS-1:0] rem_nxt;

  // One restoring step: shift in the dividend MSB, compare/subtract the divisor.
  // When there is no borrow the difference is < dvs, so BITS-wide subtraction
  // is exact; when there is a borrow shifted < dvs and also fits in BITS bits.
  always_comb begin
    shifted = {prem, dvd[BITS-1]};
    borrow  = (shifted < {1'b0, dvs});
    qbit    = ~borrow;
    rem_nxt = borrow ? shifted[BITS-1:0] : (shifted[BITS-1:0] - dvs);
  end

  // Control FSM with registered result, handshake and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dvd            <= '0;
      dvs            <= '0;
      prem           <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_quot     <= '0;
      bus.o_rem      <= '0;
      bus.o_div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            bus.o_busy <= 1'b1;
            if (bus.i_b != '0) begin
              dvd   <= bus.i_a;
              dvs   <= bus.i_b;
              prem  <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              bus.o_quot     <= '1;
              bus.o_rem      <= bus.i_a;
              bus.o_div_zero <= 1'b1;
              bus.o_done     <= 1'b1;
              state          <= DONE;
            end
          end
        end
        CALC: begin
          prem <= rem_nxt;
          dvd  <= {dvd[BITS-2:0], qbit};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(BITS-1)) begin
            bus.o_quot     <= {dvd[BITS-2:0], qbit};
            bus.o_rem      <= rem_nxt;
            bus.o_div_zero <= 1'b0;
            bus.o_done     <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          // Single-cycle result pulse; start requests seen here are dropped.
          bus.o_done <= 1'b0;
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_div.sv
// Directed and random checks of alu_seq_div against arithmetic / and %.
module tb_alu_seq_div;
  localparam int BITS = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_seq_div_if #(.BITS(BITS)) ifc ();

  alu_seq_div #(.BITS(BITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (ifc.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Start one operation from a negedge with the DUT idle. Optionally re-pulse
  // start (with junk operands) so that it is sampled at edge `glitch`.
  // Returns at a negedge with the DUT idle again.
  task automatic op(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int glitch);
    int k;
    logic [BITS-1:0] eq, er;
    logic            ez;
    int              elat;
    if (b == 0) begin
      eq = '1; er = a; ez = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; elat = BITS;
    end
    ifc.i_start = 1'b1; ifc.i_a = a; ifc.i_b = b;
    @(posedge i_clk);
    @(negedge i_clk);
    ifc.i_start = 1'b0; ifc.i_a = BITS'($urandom); ifc.i_b = BITS'($urandom);
    k = 0;
    while (!ifc.o_done && k < 40) begin
      ifc.i_start = (k == glitch - 1);
      if (ifc.i_start) begin ifc.i_a = BITS'($urandom); ifc.i_b = BITS'($urandom); end
      @(posedge i_clk);
      k++;
      @(negedge i_clk);
    end
    ifc.i_start = 1'b0;
    chk("latency", k, elat);
    chk("busy_in_done", ifc.o_busy, 1'b1);
    chk("quot", ifc.o_quot, eq);
    chk("rem", ifc.o_rem, er);
    chk("div_zero", ifc.o_div_zero, ez);
    @(negedge i_clk);
    chk("done_pulse_1cyc", ifc.o_done, 1'b0);
    chk("idle_after_done", ifc.o_busy, 1'b0);
    chk("quot_held", ifc.o_quot, eq);
    if (glitch > 0) begin
      @(negedge i_clk);
      chk("no_queued_start", ifc.o_busy, 1'b0);
    end
  endtask

  initial begin
    int k, ndone;
    int dpos[$];
    logic [BITS-1:0] ra, rb;
    ifc.i_start = 1'b0; ifc.i_a = '0; ifc.i_b = '0;

    // reset state
    #12;
    chk("rst_busy", ifc.o_busy, 1'b0);
    chk("rst_done", ifc.o_done, 1'b0);
    chk("rst_quot", ifc.o_quot, 0);
    chk("rst_rem", ifc.o_rem, 0);
    chk("rst_dz", ifc.o_div_zero, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // directed vectors
    op(8'd10, 8'd5, 0);
    op(8'd8, 8'd10, 0);
    op(8'd15, 8'd8, 0);
    op(8'b11111110, 8'b11111100, 0);
    op(8'b11111100, 8'b11111110, 0);
    op(8'd15, 8'd0, 0);
    op(8'd10, 8'd5, 0);
    op(8'd200, 8'd3, 4);

    // reset mid-operation, after edge 4
    ifc.i_start = 1'b1; ifc.i_a = 8'd123; ifc.i_b = 8'd7;
    @(posedge i_clk);
    @(negedge i_clk);
    ifc.i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", ifc.o_busy, 1'b0);
    chk("midrst_done", ifc.o_done, 1'b0);
    chk("midrst_quot", ifc.o_quot, 0);
    chk("midrst_rem", ifc.o_rem, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    ndone = 0;
    repeat (BITS + 4) begin
      @(negedge i_clk);
      if (ifc.o_done) ndone++;
    end
    chk("aborted_no_done", ndone, 0);
    op(8'd255, 8'd1, 0);

    // start held high: back-to-back operations
    ifc.i_start = 1'b1; ifc.i_a = 8'd100; ifc.i_b = 8'd7;
    for (int c = 0; c < 3 * (BITS + 2) + 2; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (ifc.o_done) begin
        dpos.push_back(c);
        chk("b2b_quot", ifc.o_quot, 100 / 7);
        chk("b2b_rem", ifc.o_rem, 100 % 7);
      end
    end
    ifc.i_start = 1'b0;
    chk("b2b_count", dpos.size(), 3);
    if (dpos.size() >= 3) begin
      chk("b2b_first", dpos[0], BITS);
      chk("b2b_gap1", dpos[1] - dpos[0], BITS + 2);
      chk("b2b_gap2", dpos[2] - dpos[1], BITS + 2);
    end
    k = 0;
    while (ifc.o_busy && k < 40) begin @(negedge i_clk); k++; end
    chk("b2b_drain", ifc.o_busy, 1'b0);

    // random operands, some divide-by-zero
    for (int n = 0; n < 40; n++) begin
      ra = BITS'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 : BITS'($urandom);
      if (n < 4) rb = BITS'(n + 1);
      op(ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
